// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter (00..99) advanced by an internal prescaler tick.
// Run/stop toggling and clear come from asynchronous push buttons that are
// synchronized and edge-detected here; the counting direction is a synchronized level.
// Digits, run state, tick and carry/borrow pulses are all registered outputs.
module bcd_counter_2digit #(
    parameter int P_TICK_DIV = 50_000_000,
    parameter int P_CNT_W    = 26
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_BtnRun,
    input  logic       i_BtnClr,
    input  logic       i_Up,
    output logic [3:0] o_NumA,
    output logic [3:0] o_NumB,
    output logic       o_Run,
    output logic       o_Tick,
    output logic       o_Carry
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [P_CNT_W-1:0] TICK_LAST = P_CNT_W'(P_TICK_DIV - 1);

    // Button shift registers: [0] first sync stage, [1] second sync stage,
    // [2] previous value of [1] for rising-edge detection.
    logic [2:0] run_sync_q, run_sync_d;
    logic [2:0] clr_sync_q, clr_sync_d;
    logic [1:0] up_sync_q, up_sync_d;

    state_t             state_q, state_d;
    logic [P_CNT_W-1:0] presc_q, presc_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;
    logic               tick_q, tick_d;
    logic               carry_q, carry_d;

    logic run_pulse;
    logic clr_pulse;
    logic up_s;
    logic tick_now;

    // Shift the raw inputs into the synchronizer chains and derive edge pulses.
    always_comb begin
        run_sync_d = {run_sync_q[1:0], i_BtnRun};
        clr_sync_d = {clr_sync_q[1:0], i_BtnClr};
        up_sync_d  = {up_sync_q[0], i_Up};
        run_pulse  = run_sync_q[1] & ~run_sync_q[2];
        clr_pulse  = clr_sync_q[1] & ~clr_sync_q[2];
        up_s       = up_sync_q[1];
    end

    // Next-state logic: clear overrides everything; a tick step and a run toggle
    // in the same cycle both take effect.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        tick_d   = 1'b0;
        carry_d  = 1'b0;
        tick_now = (state_q == ST_RUN) && (presc_q == TICK_LAST);

        if (clr_pulse) begin
            state_d = ST_STOP;
            presc_d = '0;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
        end else begin
            if (state_q == ST_RUN) begin
                presc_d = tick_now ? '0 : presc_q + P_CNT_W'(1);
            end

            if (tick_now) begin
                tick_d = 1'b1;
                if (up_s) begin
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        if (tens_q == 4'd9) begin
                            tens_d  = 4'd0;
                            carry_d = 1'b1;
                        end else begin
                            tens_d = tens_q + 4'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end else begin
                    if (ones_q == 4'd0) begin
                        ones_d = 4'd9;
                        if (tens_q == 4'd0) begin
                            tens_d  = 4'd9;
                            carry_d = 1'b1;
                        end else begin
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        ones_d = ones_q - 4'd1;
                    end
                end
            end

            if (run_pulse) begin
                state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
            end
        end
    end

    // State, prescaler, digits, pulse outputs and synchronizers with async reset.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            run_sync_q <= 3'b000;
            clr_sync_q <= 3'b000;
            up_sync_q  <= 2'b00;
            state_q    <= ST_STOP;
            presc_q    <= '0;
            tens_q     <= 4'd0;
            ones_q     <= 4'd0;
            tick_q     <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            run_sync_q <= run_sync_d;
            clr_sync_q <= clr_sync_d;
            up_sync_q  <= up_sync_d;
            state_q    <= state_d;
            presc_q    <= presc_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            tick_q     <= tick_d;
            carry_q    <= carry_d;
        end
    end

    assign o_NumA  = tens_q;
    assign o_NumB  = ones_q;
    assign o_Run   = (state_q == ST_RUN);
    assign o_Tick  = tick_q;
    assign o_Carry = carry_q;

endmodule

// File: tb/tb_bcd_counter_2digit.sv
// Bench for bcd_counter_2digit with a 4-clock tick interval.
// A behavioural reference (integer count 0..99) predicts every cycle's outputs;
// a stimulus table and hand-written sequences add fixed end-state checks.
module tb_bcd_counter_2digit;

    logic       clk;
    logic       rst_n;
    logic       btn_run;
    logic       btn_clr;
    logic       up;
    logic [3:0] num_a;
    logic [3:0] num_b;
    logic       run;
    logic       tick;
    logic       carry;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bcd_counter_2digit #(
        .P_TICK_DIV(4),
        .P_CNT_W   (3)
    ) dut (
        .i_Clk   (clk),
        .i_Rst   (rst_n),
        .i_BtnRun(btn_run),
        .i_BtnClr(btn_clr),
        .i_Up    (up),
        .o_NumA  (num_a),
        .o_NumB  (num_b),
        .o_Run   (run),
        .o_Tick  (tick),
        .o_Carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit m_r1, m_r2, m_rp, m_c1, m_c2, m_cp, m_u1, m_u2;
    bit m_run, m_tick, m_carry;
    int m_presc, m_cnt;

    logic [10:0] exp_q[$];

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_rp = 0;
        m_c1 = 0; m_c2 = 0; m_cp = 0;
        m_u1 = 0; m_u2 = 0;
        m_run = 0; m_tick = 0; m_carry = 0;
        m_presc = 0; m_cnt = 0;
    endtask

    task automatic model_clock();
        bit rpulse, cpulse, t;
        if (!rst_n) begin
            model_reset();
        end else begin
            rpulse = m_r2 && !m_rp;
            cpulse = m_c2 && !m_cp;
            t      = m_run && (m_presc == 3);
            if (cpulse) begin
                m_cnt = 0; m_run = 0; m_presc = 0; m_tick = 0; m_carry = 0;
            end else begin
                m_tick  = t;
                m_carry = 0;
                if (t) begin
                    if (m_u2) begin
                        m_carry = (m_cnt == 99);
                        m_cnt   = (m_cnt + 1) % 100;
                    end else begin
                        m_carry = (m_cnt == 0);
                        m_cnt   = (m_cnt + 99) % 100;
                    end
                end
                if (m_run) m_presc = t ? 0 : m_presc + 1;
                if (rpulse) m_run = !m_run;
            end
            m_rp = m_r2; m_r2 = m_r1; m_r1 = btn_run;
            m_cp = m_c2; m_c2 = m_c1; m_c1 = btn_clr;
            m_u2 = m_u1; m_u1 = up;
        end
    endtask

    function automatic logic [10:0] model_out();
        return {4'(m_cnt / 10), 4'(m_cnt % 10), m_run, m_tick, m_carry};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, predict at posedge, compare just after it.
    task automatic step(input logic r, input logic b_run, input logic b_clr, input logic b_up);
        logic [10:0] e;
        @(negedge clk);
        rst_n   = r;
        btn_run = b_run;
        btn_clr = b_clr;
        up      = b_up;
        @(posedge clk);
        cyc++;
        model_clock();
        exp_q.push_back(model_out());
        #1;
        e = exp_q.pop_front();
        chk($sformatf("cycle%0d {a,b,run,tick,carry}", cyc),
            32'({num_a, num_b, run, tick, carry}), 32'(e));
    endtask

    typedef struct {
        logic       run;
        logic       clr;
        logic       up;
        int         cycles;
        logic [3:0] a;
        logic [3:0] b;
        logic       r;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{0, 0, 1, 5,  4'd0, 4'd0, 1'b0};  // idle after reset release
        tbl[1]  = '{1, 0, 1, 3,  4'd0, 4'd0, 1'b1};  // run press, RUN on 3rd edge
        tbl[2]  = '{1, 0, 1, 40, 4'd1, 4'd0, 1'b1};  // held: counts 01..10
        tbl[3]  = '{0, 0, 1, 4,  4'd1, 4'd1, 1'b1};  // release, keeps running
        tbl[4]  = '{0, 1, 1, 3,  4'd0, 4'd0, 1'b0};  // clear
        tbl[5]  = '{0, 0, 0, 3,  4'd0, 4'd0, 1'b0};  // direction down, stopped
        tbl[6]  = '{1, 0, 0, 3,  4'd0, 4'd0, 1'b1};  // run
        tbl[7]  = '{0, 0, 0, 8,  4'd9, 4'd8, 1'b1};  // 00->99 borrow, 98
        tbl[8]  = '{0, 0, 1, 8,  4'd0, 4'd0, 1'b1};  // up: 99, 00 carry
        tbl[9]  = '{0, 0, 1, 4,  4'd0, 4'd1, 1'b1};  // 01
        tbl[10] = '{0, 0, 0, 8,  4'd9, 4'd9, 1'b1};  // down: 00, 99 borrow
        tbl[11] = '{0, 0, 0, 3,  4'd9, 4'd9, 1'b1};  // mid-interval

        rst_n = 1'b0; btn_run = 1'b0; btn_clr = 1'b0; up = 1'b0;
        model_reset();

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'(i), 1'(i >> 1), 1'(i >> 2));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_hold", 32'({num_a, num_b, run, tick, carry}), 32'd0);

        // Table-driven segments
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < tbl[i].cycles; k++) begin
                step(1'b1, tbl[i].run, tbl[i].clr, tbl[i].up);
            end
            chk($sformatf("row%0d {a,b,run}", i), 32'({num_a, num_b, run}),
                32'({tbl[i].a, tbl[i].b, tbl[i].r}));
        end

        // Pause with prescaler frozen at 2 (button held: one toggle only)
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("paused {a,b,run}", 32'({num_a, num_b, run}), 32'({4'd9, 4'd8, 1'b0}));
        // Resume: tick two clocks after RUN
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("resumed {a,b,run,tick}", 32'({num_a, num_b, run, tick}), 32'({4'd9, 4'd8, 1'b1, 1'b0}));
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("resume+1 tick", 32'(tick), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("resume+2 {a,b,tick}", 32'({num_a, num_b, tick}), 32'({4'd9, 4'd7, 1'b1}));

        // Count down to 57
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (157) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("at57 {a,b,run}", 32'({num_a, num_b, run}), 32'({4'd5, 4'd7, 1'b1}));

        // Clear and run together: clear wins
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr+run {a,b,run,tick}", 32'({num_a, num_b, run, tick}), 32'd0);

        // Prescaler was zeroed: first tick four clocks after RUN
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre-tick {a,b,run,tick}", 32'({num_a, num_b, run, tick}), 32'({4'd0, 4'd0, 1'b1, 1'b0}));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("borrow {a,b,tick,carry}", 32'({num_a, num_b, tick, carry}), 32'({4'd9, 4'd9, 1'b1, 1'b1}));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("borrow+1 {tick,carry}", 32'({tick, carry}), 32'd0);

        // Clear coinciding with a tick
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr+tick {a,b,run,tick,carry}", 32'({num_a, num_b, run, tick, carry}), 32'd0);

        // Count up to 42, then async reset mid-interval
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
        repeat (169) step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("at42 {a,b,run}", 32'({num_a, num_b, run}), 32'({4'd4, 4'd2, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'({num_a, num_b, run, tick, carry}), 32'd0);
        model_reset();
        repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("post_reset idle", 32'({num_a, num_b, run, tick, carry}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
